frame_scheduler: RTL and testbench

Per-frame update sequencer for the game datapath. On each `new_frame` pulse from `vga_scan` it starts the game-object update units (bird physics, pipe scroll, stage shift, collision/score) one at a time in fixed index order using a start/done handshake. Each unit has a watchdog. Overrun and timeout are reported so all state updates finish inside the blanking interval, before the renderers read positions again.

---
 rtl/frame_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_frame_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scheduler.sv
// frame_scheduler: per-frame sequencer that starts update units one at a time
// in index order with a start/done handshake and a per-unit watchdog.
module frame_scheduler #(
    parameter int unsigned N_UNITS = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               new_frame,
    input  logic               pause,
    input  logic [N_UNITS-1:0] unit_enable,
    input  logic [N_UNITS-1:0] unit_done,
    input  logic               err_clear,
    output logic [N_UNITS-1:0] unit_start,
    output logic               busy,
    output logic               frame_done,
    output logic [15:0]        frame_count,
    output logic [N_UNITS-1:0] err_mask,
    output logic [7:0]         overrun_count
);

    localparam int unsigned IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [N_UNITS-1:0] r_mask;
    logic [N_UNITS-1:0] w_mask_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_nxt;

    logic [N_UNITS-1:0] r_unit_start;
    logic               r_busy;
    logic               r_frame_done;
    logic [15:0]        r_frame_count;
    logic [N_UNITS-1:0] r_err_mask;
    logic [7:0]         r_overrun_count;

    logic               w_first_vld;
    logic [IDX_W-1:0]   w_first_idx;
    logic               w_next_vld;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_accept;
    logic               w_unit_end;
    logic [N_UNITS-1:0] w_err_set;
    logic               w_overrun;

    logic [N_UNITS-1:0] w_unit_start_nxt;
    logic               w_busy_nxt;
    logic               w_frame_done_nxt;
    logic [15:0]        w_frame_count_nxt;
    logic [N_UNITS-1:0] w_err_mask_nxt;
    logic [7:0]         w_overrun_count_nxt;

    // Lowest enabled unit for a new frame, and next latched unit above the current index
    always_comb begin
        w_first_vld = 1'b0;
        w_first_idx = '0;
        w_next_vld  = 1'b0;
        w_next_idx  = '0;
        for (int i = int'(N_UNITS) - 1; i >= 0; i--) begin
            if (unit_enable[i]) begin
                w_first_vld = 1'b1;
                w_first_idx = IDX_W'(i);
            end
            if (r_mask[i] && (i > int'(r_idx))) begin
                w_next_vld = 1'b1;
                w_next_idx = IDX_W'(i);
            end
        end
    end

    // State register and sequencing context
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_mask  <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_mask  <= w_mask_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Next-state logic, watchdog, and next values of the registered outputs
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_mask_nxt  = r_mask;
        w_timer_nxt = r_timer;
        w_accept    = 1'b0;
        w_unit_end  = 1'b0;
        w_err_set   = '0;
        w_overrun   = new_frame && (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (new_frame && !pause) begin
                    w_accept   = 1'b1;
                    w_mask_nxt = unit_enable;
                    if (w_first_vld) begin
                        w_idx_nxt   = w_first_idx;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_FINISH;
                    end
                end
            end
            S_ISSUE: begin
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (unit_done[r_idx]) begin
                    w_unit_end = 1'b1;
                end else if (r_timer == TMR_LAST) begin
                    w_unit_end       = 1'b1;
                    w_err_set[r_idx] = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
                if (w_unit_end) begin
                    if (w_next_vld) begin
                        w_idx_nxt   = w_next_idx;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_unit_start_nxt = (w_state_nxt == S_ISSUE) ? (N_UNITS'(1) << w_idx_nxt) : '0;
        w_busy_nxt       = (w_state_nxt != S_IDLE);
        w_frame_done_nxt = (w_state_nxt == S_FINISH);

        w_frame_count_nxt = w_accept ? (r_frame_count + 16'd1) : r_frame_count;

        // A set event in the same cycle as a clear survives the clear
        w_err_mask_nxt = (err_clear ? '0 : r_err_mask) | w_err_set;

        if (w_overrun) begin
            if (err_clear) begin
                w_overrun_count_nxt = 8'd1;
            end else if (r_overrun_count == 8'hFF) begin
                w_overrun_count_nxt = 8'hFF;
            end else begin
                w_overrun_count_nxt = r_overrun_count + 8'd1;
            end
        end else if (err_clear) begin
            w_overrun_count_nxt = 8'd0;
        end else begin
            w_overrun_count_nxt = r_overrun_count;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_unit_start    <= '0;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_count   <= '0;
            r_err_mask      <= '0;
            r_overrun_count <= '0;
        end else begin
            r_unit_start    <= w_unit_start_nxt;
            r_busy          <= w_busy_nxt;
            r_frame_done    <= w_frame_done_nxt;
            r_frame_count   <= w_frame_count_nxt;
            r_err_mask      <= w_err_mask_nxt;
            r_overrun_count <= w_overrun_count_nxt;
        end
    end

    assign unit_start    = r_unit_start;
    assign busy          = r_busy;
    assign frame_done    = r_frame_done;
    assign frame_count   = r_frame_count;
    assign err_mask      = r_err_mask;
    assign overrun_count = r_overrun_count;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed self-checking bench for frame_scheduler (N_UNITS=4, TIMEOUT=16).
module tb_frame_scheduler;

    logic        clk;
    logic        rstn;
    logic        new_frame;
    logic        pause;
    logic [3:0]  unit_enable;
    logic [3:0]  unit_done;
    logic        err_clear;
    logic [3:0]  unit_start;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [3:0]  err_mask;
    logic [7:0]  overrun_count;

    // Unit responder controls
    logic [3:0]  silent;
    logic [3:0]  stray;
    logic [3:0]  rdone;
    int          dly;
    int          cnt [4];

    int          n_cmp;
    int          n_err;
    logic [15:0] exp_fc;
    logic [3:0]  exp_s;
    logic        exp_b;
    logic        exp_d;
    logic [3:0]  exp_e;
    logic [7:0]  exp_o;

    frame_scheduler #(.N_UNITS(4), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .new_frame     (new_frame),
        .pause         (pause),
        .unit_enable   (unit_enable),
        .unit_done     (unit_done),
        .err_clear     (err_clear),
        .unit_start    (unit_start),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .err_mask      (err_mask),
        .overrun_count (overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model units: answer 'dly' cycles after their start unless silenced
    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) cnt[i] = 0;
            rdone = 4'h0;
        end else begin
            rdone = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (cnt[i] != 0) begin
                    cnt[i] = cnt[i] - 1;
                    if (cnt[i] == 0) rdone[i] = 1'b1;
                end
                if (unit_start[i] && !silent[i]) cnt[i] = dly;
            end
        end
    end
    assign unit_done = rdone | stray;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; new_frame = 1'b0; pause = 1'b0; err_clear = 1'b0;
        unit_enable = 4'h0; silent = 4'h0; stray = 4'h0; dly = 3; exp_fc = 16'd0;
        repeat (3) tick();
        n_cmp++; if ({unit_start, busy, frame_done} !== 6'b0) begin n_err++; $display("FAIL reset ctrl got %b want 0", {unit_start, busy, frame_done}); end
        n_cmp++; if ({frame_count, err_mask, overrun_count} !== 28'h0) begin n_err++; $display("FAIL reset cnt got %h want 0", {frame_count, err_mask, overrun_count}); end
        rstn = 1'b1;
        tick();
        n_cmp++; if ({unit_start, busy, frame_done, frame_count} !== 22'h0) begin n_err++; $display("FAIL reset_rel got %h want 0", {unit_start, busy, frame_done, frame_count}); end
    endtask

    task automatic test_full_mask;
        unit_enable = 4'hF; silent = 4'h0; dly = 3;
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        exp_fc = exp_fc + 16'd1;
        for (int n = 1; n <= 19; n++) begin
            exp_s = (n <= 13 && (n - 1) % 4 == 0) ? 4'(1 << ((n - 1) / 4)) : 4'h0;
            exp_d = (n == 17);
            exp_b = (n <= 17);
            n_cmp++; if (unit_start !== exp_s) begin n_err++; $display("FAIL full start n=%0d got %h want %h", n, unit_start, exp_s); end
            n_cmp++; if (frame_done !== exp_d) begin n_err++; $display("FAIL full frame_done n=%0d got %b want %b", n, frame_done, exp_d); end
            n_cmp++; if (busy !== exp_b) begin n_err++; $display("FAIL full busy n=%0d got %b want %b", n, busy, exp_b); end
            tick();
        end
        n_cmp++; if (frame_count !== exp_fc) begin n_err++; $display("FAIL full frame_count got %0d want %0d", frame_count, exp_fc); end
        n_cmp++; if (err_mask !== 4'h0) begin n_err++; $display("FAIL full err_mask got %h want 0", err_mask); end
    endtask

    task automatic test_sparse_mask;
        unit_enable = 4'b1010; silent = 4'h0; dly = 3;
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        stray = 4'b0001;
        exp_fc = exp_fc + 16'd1;
        for (int n = 1; n <= 11; n++) begin
            exp_s = (n == 1) ? 4'b0010 : (n == 5) ? 4'b1000 : 4'h0;
            exp_d = (n == 9);
            exp_b = (n <= 9);
            n_cmp++; if (unit_start !== exp_s) begin n_err++; $display("FAIL sparse start n=%0d got %h want %h", n, unit_start, exp_s); end
            n_cmp++; if (frame_done !== exp_d) begin n_err++; $display("FAIL sparse frame_done n=%0d got %b want %b", n, frame_done, exp_d); end
            n_cmp++; if (busy !== exp_b) begin n_err++; $display("FAIL sparse busy n=%0d got %b want %b", n, busy, exp_b); end
            tick();
        end
        stray = 4'h0;
        n_cmp++; if (frame_count !== exp_fc) begin n_err++; $display("FAIL sparse frame_count got %0d want %0d", frame_count, exp_fc); end
    endtask

    task automatic test_timeout;
        unit_enable = 4'hF; silent = 4'b0100; dly = 3;
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        exp_fc = exp_fc + 16'd1;
        for (int n = 1; n <= 31; n++) begin
            exp_s = (n == 1) ? 4'h1 : (n == 5) ? 4'h2 : (n == 9) ? 4'h4 : (n == 26) ? 4'h8 : 4'h0;
            exp_d = (n == 30);
            exp_e = (n >= 26) ? 4'b0100 : 4'h0;
            n_cmp++; if (unit_start !== exp_s) begin n_err++; $display("FAIL timeout start n=%0d got %h want %h", n, unit_start, exp_s); end
            n_cmp++; if (frame_done !== exp_d) begin n_err++; $display("FAIL timeout frame_done n=%0d got %b want %b", n, frame_done, exp_d); end
            n_cmp++; if (err_mask !== exp_e) begin n_err++; $display("FAIL timeout err_mask n=%0d got %h want %h", n, err_mask, exp_e); end
            tick();
        end
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        n_cmp++; if (err_mask !== 4'h0) begin n_err++; $display("FAIL err_clear got %h want 0", err_mask); end
        n_cmp++; if (frame_count !== exp_fc) begin n_err++; $display("FAIL timeout frame_count got %0d want %0d", frame_count, exp_fc); end
    endtask

    task automatic test_timeout_boundary;
        unit_enable = 4'b0001; silent = 4'h0; dly = 16;
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        exp_fc = exp_fc + 16'd1;
        for (int n = 1; n <= 19; n++) begin
            exp_d = (n == 18);
            n_cmp++; if (frame_done !== exp_d) begin n_err++; $display("FAIL boundary frame_done n=%0d got %b want %b", n, frame_done, exp_d); end
            tick();
        end
        n_cmp++; if (err_mask !== 4'h0) begin n_err++; $display("FAIL boundary err_mask got %h want 0", err_mask); end
        dly = 3;
    endtask

    task automatic test_overrun;
        unit_enable = 4'hF; silent = 4'h0; dly = 3;
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        exp_fc = exp_fc + 16'd2;
        for (int n = 1; n <= 37; n++) begin
            if (n <= 13 && (n - 1) % 4 == 0) exp_s = 4'(1 << ((n - 1) / 4));
            else if (n >= 19 && n <= 31 && (n - 19) % 4 == 0) exp_s = 4'(1 << ((n - 19) / 4));
            else exp_s = 4'h0;
            exp_d = (n == 17) || (n == 35);
            exp_b = (n <= 17) || (n >= 19 && n <= 35);
            exp_o = (n <= 5) ? 8'd0 : (n <= 17) ? 8'd1 : 8'd2;
            n_cmp++; if (unit_start !== exp_s) begin n_err++; $display("FAIL overrun start n=%0d got %h want %h", n, unit_start, exp_s); end
            n_cmp++; if (busy !== exp_b) begin n_err++; $display("FAIL overrun busy n=%0d got %b want %b", n, busy, exp_b); end
            n_cmp++; if (frame_done !== exp_d) begin n_err++; $display("FAIL overrun frame_done n=%0d got %b want %b", n, frame_done, exp_d); end
            n_cmp++; if (overrun_count !== exp_o) begin n_err++; $display("FAIL overrun count n=%0d got %0d want %0d", n, overrun_count, exp_o); end
            new_frame = (n == 5) || (n == 17) || (n == 18);
            tick();
        end
        new_frame = 1'b0;
        n_cmp++; if (frame_count !== exp_fc) begin n_err++; $display("FAIL overrun frame_count got %0d want %0d", frame_count, exp_fc); end
    endtask

    task automatic test_pause_and_empty;
        unit_enable = 4'hF; pause = 1'b1;
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        n_cmp++; if ({unit_start, busy} !== 5'b0) begin n_err++; $display("FAIL pause ctrl got %b want 0", {unit_start, busy}); end
        tick();
        n_cmp++; if (unit_start !== 4'h0) begin n_err++; $display("FAIL pause start got %h want 0", unit_start); end
        n_cmp++; if (frame_count !== exp_fc) begin n_err++; $display("FAIL pause frame_count got %0d want %0d", frame_count, exp_fc); end
        pause = 1'b0;
        unit_enable = 4'h0;
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        exp_fc = exp_fc + 16'd1;
        n_cmp++; if ({frame_done, busy, unit_start} !== 6'b110000) begin n_err++; $display("FAIL empty c+1 got %b want 110000", {frame_done, busy, unit_start}); end
        tick();
        n_cmp++; if ({frame_done, busy, unit_start} !== 6'b0) begin n_err++; $display("FAIL empty c+2 got %b want 0", {frame_done, busy, unit_start}); end
        n_cmp++; if (frame_count !== exp_fc) begin n_err++; $display("FAIL empty frame_count got %0d want %0d", frame_count, exp_fc); end
    endtask

    task automatic test_saturate_and_clear;
        int k;
        unit_enable = 4'hF; silent = 4'hF;
        new_frame = 1'b1;
        repeat (300) tick();
        new_frame = 1'b0;
        k = 0;
        while (busy && k < 500) begin tick(); k++; end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sat idle_wait got busy=%b want 0", busy); end
        n_cmp++; if (overrun_count !== 8'd255) begin n_err++; $display("FAIL sat overrun got %0d want 255", overrun_count); end
        // Overrun increment coincident with clear
        new_frame = 1'b1; tick();
        err_clear = 1'b1; tick();
        new_frame = 1'b0; err_clear = 1'b0;
        n_cmp++; if (overrun_count !== 8'd1) begin n_err++; $display("FAIL clr_race overrun got %0d want 1", overrun_count); end
        n_cmp++; if (err_mask !== 4'h0) begin n_err++; $display("FAIL clr_race err_mask got %h want 0", err_mask); end
        k = 0;
        while (busy && k < 200) begin tick(); k++; end
        n_cmp++; if (err_mask !== 4'hF) begin n_err++; $display("FAIL all_silent err_mask got %h want f", err_mask); end
        // Timeout set coincident with clear
        unit_enable = 4'b0001;
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        for (int n = 1; n < 17; n++) tick();
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        n_cmp++; if (err_mask !== 4'b0001) begin n_err++; $display("FAIL set_race err_mask got %h want 1", err_mask); end
        n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL set_race frame_done got %b want 1", frame_done); end
        tick();
        silent = 4'h0;
    endtask

    task automatic test_reset_mid_wait;
        unit_enable = 4'hF; silent = 4'h0; dly = 3;
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        tick();
        rstn = 1'b0;
        #1;
        n_cmp++; if ({unit_start, busy, frame_done} !== 6'b0) begin n_err++; $display("FAIL midrst ctrl got %b want 0", {unit_start, busy, frame_done}); end
        n_cmp++; if ({frame_count, err_mask, overrun_count} !== 28'h0) begin n_err++; $display("FAIL midrst cnt got %h want 0", {frame_count, err_mask, overrun_count}); end
        tick(); tick();
        rstn = 1'b1;
        tick();
        new_frame = 1'b1; tick(); new_frame = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            exp_s = (n <= 13 && (n - 1) % 4 == 0) ? 4'(1 << ((n - 1) / 4)) : 4'h0;
            exp_d = (n == 17);
            n_cmp++; if (unit_start !== exp_s) begin n_err++; $display("FAIL postrst start n=%0d got %h want %h", n, unit_start, exp_s); end
            n_cmp++; if (frame_done !== exp_d) begin n_err++; $display("FAIL postrst frame_done n=%0d got %b want %b", n, frame_done, exp_d); end
            tick();
        end
        n_cmp++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL postrst frame_count got %0d want 1", frame_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_timeout();
        test_timeout_boundary();
        test_overrun();
        test_pause_and_empty();
        test_saturate_and_clear();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
